// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths and ALU command encodings
//
// Purpose: single definition of the datapath width, register address width
//          and ALU command codes used by decode, the EX operand stage and the ALU.
// Ports:   none (package).
package pipe_pkg;

  localparam int DATA_W = 16;
  localparam int RA_W   = 3;
  localparam int CMD_W  = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_AND = 4'd3,
    CMD_OR  = 4'd4,
    CMD_XOR = 4'd5,
    CMD_SL  = 4'd6,
    CMD_SR  = 4'd7,
    CMD_SRU = 4'd8,
    CMD_MUL = 4'd9
  } alu_cmd_e;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - three-source operand forwarding select
//
// Purpose: picks the freshest value of one source register: MEM-stage result,
//          else WB-stage result, else the value read from the register file.
//          Register 0 never forwards and always reads as zero.
// Ports:   src_addr/reg_data         register number and registered read data
//          mem_reg_write/rd/result   MEM-stage forwarding source
//          wb_reg_write/rd/result    WB-stage forwarding source
//          fwd_data                  selected operand (combinational)
module fwd_mux #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int RA_W   = pipe_pkg::RA_W
) (
  input  logic [RA_W-1:0]   src_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_reg_write,
  input  logic [RA_W-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_rd_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] fwd_data
);

  // MEM is checked before WB: it holds the younger write to the same register.
  always_comb begin
    fwd_data = reg_data;
    if (src_addr == '0) begin
      fwd_data = '0;
    end else if (mem_reg_write && (mem_rd_addr == src_addr)) begin
      fwd_data = mem_result;
    end else if (wb_reg_write && (wb_rd_addr == src_addr)) begin
      fwd_data = wb_result;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with load-use stall and forwarding
//
// Purpose: captures the decode slot each cycle, inserts a bubble on flush or
//          load-use hazard, and presents forwarded ALU operands and store data.
// Ports:   clk, rst                   clock, asynchronous active-high reset
//          id_*                       decode-stage instruction fields
//          flush                      squash the decode slot
//          mem_*, wb_*                forwarding sources
//          stall                      load-use hazard, freezes PC and IF/ID
//          alu_a, alu_b, alu_cmd      ALU operands and command
//          ex_*                       registered control, destination, store data
module ex_operand_stage #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int RA_W   = pipe_pkg::RA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs_addr,
  input  logic [RA_W-1:0]   id_rt_addr,
  input  logic [RA_W-1:0]   id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [3:0]        id_cmd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              mem_reg_write,
  input  logic [RA_W-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_rd_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic              stall,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_cmd,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [RA_W-1:0]   ex_rd_addr,
  output logic [DATA_W-1:0] ex_store_data
);

  import pipe_pkg::*;

  logic [RA_W-1:0]   ex_rs_addr;
  logic [RA_W-1:0]   ex_rt_addr;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic              ex_use_imm;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic              rd_hits_src;

  // A load in EX cannot forward its data until it reaches MEM, so a dependent
  // instruction in ID must wait one cycle. rt counts as a source when it feeds
  // the ALU or supplies store data.
  assign rd_hits_src = (ex_rd_addr == id_rs_addr) ||
                       ((ex_rd_addr == id_rt_addr) && !id_use_imm) ||
                       ((ex_rd_addr == id_rt_addr) && id_mem_write);

  assign stall = id_valid && ex_valid && ex_mem_read &&
                 (ex_rd_addr != '0) && rd_hits_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      alu_cmd      <= CMD_NOP;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_rd_addr   <= '0;
      ex_rs_addr   <= '0;
      ex_rt_addr   <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_use_imm   <= 1'b0;
    end else if (flush || stall) begin
      // Bubble: data fields are left as they were, nothing downstream looks at them.
      ex_valid     <= 1'b0;
      alu_cmd      <= CMD_NOP;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else begin
      // An empty decode slot is also a bubble, so its command and controls are
      // gated to keep the ALU holding its previous result.
      ex_valid     <= id_valid;
      alu_cmd      <= id_valid ? id_cmd : CMD_NOP;
      ex_reg_write <= id_valid & id_reg_write;
      ex_mem_read  <= id_valid & id_mem_read;
      ex_mem_write <= id_valid & id_mem_write;
      ex_rd_addr   <= id_rd_addr;
      ex_rs_addr   <= id_rs_addr;
      ex_rt_addr   <= id_rt_addr;
      ex_rs_data   <= id_rs_data;
      ex_rt_data   <= id_rt_data;
      ex_imm       <= id_imm;
      ex_use_imm   <= id_use_imm;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs (
    .src_addr      (ex_rs_addr),
    .reg_data      (ex_rs_data),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .fwd_data      (rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rt (
    .src_addr      (ex_rt_addr),
    .reg_data      (ex_rt_data),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .fwd_data      (rt_fwd)
  );

  assign alu_a         = rs_fwd;
  assign alu_b         = ex_use_imm ? ex_imm : rt_fwd;
  assign ex_store_data = rt_fwd;

endmodule
